// File: rtl/fracn_div_seq_pkg.sv
// Shared definitions for the fractional-N divider sequencer: default widths,
// reset ratio and the sequencer state encoding.
package fracn_pkg;

  localparam int DEF_WIDTH   = 9;
  localparam int DEF_INT_W   = 8;
  localparam int DEF_INT_MIN = 4;
  localparam int DEF_INT_MAX = 250;
  localparam int DEF_INT_DEF = 16;
  localparam int DEF_SETTLE  = 32;

  // state     | meaning
  // ST_IDLE   | stopped, ratio and modulator phase held
  // ST_RUN    | stepping, settle count expired
  // ST_SETTLE | stepping, waiting for settle count after enable or word change
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

endpackage

// File: rtl/fracn_div_seq_if.sv
// Control/status bundle between the divider sequencer and its host/MMD.
// phase exposes the modulator residue so the phase can be observed directly.
interface fracn_div_seq_if #(
  parameter int WIDTH = fracn_pkg::DEF_WIDTH,
  parameter int INT_W = fracn_pkg::DEF_INT_W
);
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [INT_W-1:0] cfg_int;
  logic [WIDTH-1:0] cfg_frac;
  logic             div_done;
  logic [INT_W-1:0] ratio;
  logic             ratio_valid;
  logic             settled;
  logic             err;
  logic             busy;
  logic [WIDTH-1:0] phase;

  modport master (
    output en, cfg_valid, cfg_int, cfg_frac, div_done,
    input  cfg_ready, ratio, ratio_valid, settled, err, busy, phase
  );

  modport slave (
    input  en, cfg_valid, cfg_int, cfg_frac, div_done,
    output cfg_ready, ratio, ratio_valid, settled, err, busy, phase
  );
endinterface

// File: rtl/fracn_div_seq_efm.sv
// Clock-enabled first-order error-feedback modulator. Each enabled clock adds
// x into the residue e; y is the carry out of that addition for this step.
module fracn_efm_ce
  import fracn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] x,
  output logic             y,
  output logic [WIDTH-1:0] e
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, e} + {1'b0, x};
  assign y   = sum[WIDTH];

  // Residue advances only on enabled steps; it is never cleared by word changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     e <= '0;
    else if (ce) e <= sum[WIDTH-1:0];
  end

endmodule

// File: rtl/fracn_div_seq.sv
// Fractional-N divider sequencer: range-checks and shadows new divide words,
// applies them at period boundaries and issues one modulus per MMD period.
module fracn_div_seq
  import fracn_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int INT_W      = DEF_INT_W,
  parameter int INT_MIN    = DEF_INT_MIN,
  parameter int INT_MAX    = DEF_INT_MAX,
  parameter int INT_DEF    = DEF_INT_DEF,
  parameter int SETTLE_CYC = DEF_SETTLE
) (
  input logic            clk,
  input logic            rst,
  fracn_div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_base;
  logic             pending;
  logic [INT_W-1:0] sh_int, act_int, int_sel;
  logic [WIDTH-1:0] sh_frac, act_frac, frac_sel;
  logic             step, apply, xfer, legal, carry;
  logic [WIDTH-1:0] acc;

  assign bus.cfg_ready = !pending;
  assign xfer  = bus.cfg_valid && !pending;
  assign legal = (bus.cfg_int >= INT_W'(INT_MIN)) && (bus.cfg_int <= INT_W'(INT_MAX - 1));
  assign step  = bus.en && bus.div_done;
  // A pending word takes effect for the very period it is applied in.
  assign apply    = step && pending;
  assign int_sel  = apply ? sh_int  : act_int;
  assign frac_sel = apply ? sh_frac : act_frac;

  assign bus.busy    = (state != ST_IDLE);
  assign bus.settled = (state == ST_RUN);
  assign bus.phase   = acc;

  fracn_efm_ce #(.WIDTH(WIDTH)) u_efm (
    .clk (clk),
    .rst (rst),
    .ce  (step),
    .x   (frac_sel),
    .y   (carry),
    .e   (acc)
  );

  // Settle count reloads on enable or word change and counts down one per step;
  // the state follows from whether it has expired after this step.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_base  = cnt;
    if (step) begin
      if (apply || state == ST_IDLE) cnt_base = CNT_W'(SETTLE_CYC);
      cnt_nxt   = (cnt_base == '0) ? '0 : cnt_base - CNT_W'(1);
      state_nxt = (cnt_nxt == '0) ? ST_RUN : ST_SETTLE;
    end
    if (!bus.en) state_nxt = ST_IDLE;
  end

  // Sequencer state and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= CNT_W'(SETTLE_CYC);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Shadow/active word registers; capture and apply never coincide since
  // capture needs the slot empty and apply needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      sh_int   <= INT_W'(INT_DEF);
      sh_frac  <= '0;
      act_int  <= INT_W'(INT_DEF);
      act_frac <= '0;
      bus.err  <= 1'b0;
    end else begin
      bus.err <= xfer && !legal;
      if (apply) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
        pending  <= 1'b0;
      end else if (xfer && legal) begin
        sh_int  <= bus.cfg_int;
        sh_frac <= bus.cfg_frac;
        pending <= 1'b1;
      end
    end
  end

  // Modulus for the next MMD period, one clock after the period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ratio       <= INT_W'(INT_DEF);
      bus.ratio_valid <= 1'b0;
    end else begin
      bus.ratio_valid <= step;
      if (step) bus.ratio <= int_sel + {{(INT_W-1){1'b0}}, carry};
    end
  end

endmodule

// File: tb/tb_fracn_div_seq.sv
// Directed and randomized checks of the divider sequencer against an
// arithmetic reference model of the divide-word and modulator behaviour.
module tb_fracn_div_seq;

  localparam int W      = 9;
  localparam int IW     = 8;
  localparam int SETTLE = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  fracn_div_seq_if #(.WIDTH(W), .INT_W(IW)) bus ();

  fracn_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model
  int m_acc, m_int, m_frac, m_ratio, m_since;
  int m_sh_int, m_sh_frac;
  bit m_pend, m_active, m_en;
  int n16, n17;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic m_reset();
    m_acc = 0; m_int = 16; m_frac = 0; m_ratio = 16; m_since = 0;
    m_pend = 0; m_active = 0; m_sh_int = 16; m_sh_frac = 0;
  endtask

  task automatic set_en(input bit b);
    bus.en = b;
    m_en = b;
  endtask

  task automatic cycle(input bit dd, input bit v, input logic [7:0] ni, input logic [8:0] nf);
    bit rdy_exp, stp, err_exp;
    bus.div_done = dd;
    bus.cfg_valid = v;
    bus.cfg_int = ni;
    bus.cfg_frac = nf;
    rdy_exp = !m_pend;
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(rdy_exp));
    stp = dd && m_en;
    if (stp) begin
      if (m_pend) begin
        m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0; m_since = 0;
      end
      if (!m_active) m_since = 0;
      m_active = 1;
      m_since++;
      m_acc = m_acc + m_frac;
      m_ratio = m_int + m_acc / 512;
      m_acc = m_acc % 512;
    end
    if (!m_en) m_active = 0;
    err_exp = 0;
    if (v && rdy_exp) begin
      if (ni >= 4 && ni <= 249) begin
        m_pend = 1; m_sh_int = ni; m_sh_frac = nf;
      end else err_exp = 1;
    end
    @(posedge clk); #1;
    bus.div_done = 1'b0;
    bus.cfg_valid = 1'b0;
    chk("ratio_valid", 32'(bus.ratio_valid), 32'(stp));
    chk("ratio", 32'(bus.ratio), 32'(m_ratio));
    chk("err", 32'(bus.err), 32'(err_exp));
    chk("settled", 32'(bus.settled), 32'(m_active && m_since >= SETTLE));
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("phase", 32'(bus.phase), 32'(m_acc));
  endtask

  task automatic period(input int gap);
    cycle(1'b1, 1'b0, 8'd0, 9'd0);
    for (int k = 1; k < gap; k++) cycle(1'b0, 1'b0, 8'd0, 9'd0);
  endtask

  task automatic offer(input logic [7:0] ni, input logic [8:0] nf);
    cycle(1'b0, 1'b1, ni, nf);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ratio"}, 32'(bus.ratio), 32'd16);
    chk({tag, "_valid"}, 32'(bus.ratio_valid), 32'd0);
    chk({tag, "_settled"}, 32'(bus.settled), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ready"}, 32'(bus.cfg_ready), 32'd1);
    chk({tag, "_phase"}, 32'(bus.phase), 32'd0);
  endtask

  initial begin
    bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_int = '0;
    bus.cfg_frac = '0; bus.div_done = 1'b0;
    m_en = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_rel");

    // 1) long-run carry density with N=16, frac=254
    offer(8'd16, 9'd254);
    set_en(1'b1);
    n16 = 0; n17 = 0;
    for (int p = 0; p < 512; p++) begin
      cycle(1'b1, 1'b0, 8'd0, 9'd0);
      if (bus.ratio == 8'd16) n16++;
      if (bus.ratio == 8'd17) n17++;
      repeat (7) cycle(1'b0, 1'b0, 8'd0, 9'd0);
    end
    chk("count17", 32'(n17), 32'd254);
    chk("count16", 32'(n16), 32'd258);

    // 2) integer-only word, settle behaviour with random period lengths
    offer(8'd20, 9'd0);
    for (int p = 0; p < 40; p++) period($urandom_range(1, 4));
    chk("const20", 32'(bus.ratio), 32'd20);
    chk("settled_run", 32'(bus.settled), 32'd1);

    // 3) word offered in the same clock as a period boundary
    cycle(1'b1, 1'b1, 8'd30, 9'd128);
    chk("same_clk_ratio", 32'(bus.ratio), 32'd20);
    period(2);
    chk("new_word_settle_drop", 32'(bus.settled), 32'd0);
    for (int p = 0; p < 34; p++) period($urandom_range(1, 3));

    // 4) range check at both edges
    offer(8'd3, 9'd5);
    offer(8'd250, 9'd5);
    period(2);
    chk("rejected_ratio", 32'(bus.ratio >= 8'd30 && bus.ratio <= 8'd31), 32'd1);
    offer(8'd249, 9'($urandom));
    for (int p = 0; p < 4; p++) period(1);
    chk("ratio_249", 32'(bus.ratio == 8'd249 || bus.ratio == 8'd250), 32'd1);

    // 5) second word while one is pending
    offer(8'd100, 9'd7);
    offer(8'd120, 9'd9);
    period(2);
    offer(8'd120, 9'd9);
    period(1);
    period(1);

    // 6) disable mid-run, re-enable, then reset mid-run with a word pending
    set_en(1'b0);
    cycle(1'b0, 1'b0, 8'd0, 9'd0);
    for (int p = 0; p < 3; p++) period(2);
    set_en(1'b1);
    for (int p = 0; p < 5; p++) period($urandom_range(1, 3));
    offer(8'd50, 9'd300);
    rst = 1'b1;
    #1;
    m_reset();
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int p = 0; p < 5; p++) period(2);

    // random traffic: back-to-back boundaries, random words, en toggles
    offer(8'd77, 9'd333);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) set_en(!m_en);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)), 9'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
